// File: rtl/i2c_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// i2c_rx_byte_fifo
// Byte buffer between the I2C controller's received-data output and the
// host-side logic. Each byte the controller flags as complete is stored in a
// first-word-fall-through FIFO and handed on over a valid/ready handshake.
// When the host falls behind, new bytes are dropped rather than stalling the
// bus side, and the drops are counted in a saturating counter.
// ---------------------------------------------------------------------------
module i2c_rx_byte_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DROP_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        i_inData,
   input  logic              i_inValid,
   output logic [7:0]        o_outData,
   output logic              o_outValid,
   input  logic              i_outReady,
   output logic [ADDR_W:0]   o_level,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_overflow,
   output logic [DROP_W-1:0] o_dropCount,
   input  logic              i_clrOvf
);

   // Occupancy value that means "every entry holds a byte".
   localparam logic [ADDR_W:0] LP_FULL_LEVEL = DEPTH[ADDR_W:0];

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wrPtr;
   logic [ADDR_W-1:0] r_rdPtr;
   logic [ADDR_W:0]   r_level;
   logic              r_full;
   logic              r_empty;
   logic              r_overflow;
   logic [DROP_W-1:0] r_dropCount;

   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic [ADDR_W:0]   w_levelNext;

   // Handshake decode. A pop frees a slot in the same edge, so a push into a
   // full FIFO is still accepted when the head byte leaves at the same time.
   // Only a push that finds the FIFO full with no pop turns into a drop.
   always_comb begin
      w_pop  = 1'b0;
      w_push = 1'b0;
      w_drop = 1'b0;
      w_pop  = !r_empty && i_outReady;
      w_push = i_inValid && (!r_full || w_pop);
      w_drop = i_inValid && r_full && !w_pop;
   end

   // Next occupancy: up on a lone push, down on a lone pop, unchanged when
   // both or neither happen. FULL/EMPTY are derived from this so they are
   // registered alongside the level itself.
   always_comb begin
      w_levelNext = r_level;
      case ({w_push, w_pop})
         2'b10:   w_levelNext = r_level + 1'b1;
         2'b01:   w_levelNext = r_level - 1'b1;
         default: w_levelNext = r_level;
      endcase
   end

   // Storage array. It carries no reset because an entry is only ever read
   // after a push has written it; the pointers alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= i_inData;
      end
   end

   // Pointers, occupancy and the registered full/empty flags. The pointers
   // are exactly log2(DEPTH) bits wide so they wrap naturally.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         r_level <= w_levelNext;
         r_full  <= (w_levelNext == LP_FULL_LEVEL);
         r_empty <= (w_levelNext == '0);
      end
   end

   // Overflow bookkeeping. A drop in the same cycle as a clear wins, leaving
   // the sticky flag set and the counter at one so that drop is not lost.
   // The counter sticks at all-ones instead of wrapping back to a small value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow  <= 1'b0;
         r_dropCount <= '0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_clrOvf) begin
               r_dropCount <= {{(DROP_W-1){1'b0}}, 1'b1};
            end else if (r_dropCount != '1) begin
               r_dropCount <= r_dropCount + 1'b1;
            end
         end else if (i_clrOvf) begin
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
         end
      end
   end

   // Output drive. The head byte is read straight from the array with no
   // latency; it is forced to zero while empty so the data bus shows a clean
   // value during and right after reset instead of stale memory contents.
   always_comb begin
      o_outData   = 8'h00;
      if (!r_empty) begin
         o_outData = r_mem[r_rdPtr];
      end
      o_outValid  = !r_empty;
      o_level     = r_level;
      o_full      = r_full;
      o_empty     = r_empty;
      o_overflow  = r_overflow;
      o_dropCount = r_dropCount;
   end

endmodule

// File: tb/tb_i2c_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// tb_i2c_rx_byte_fifo
// Directed bench for the I2C receive byte FIFO. A queue-based model tracks
// what the FIFO must hold; a compare process checks every DUT output against
// it on each falling clock edge, and literal checks pin the model at the
// interesting points of each scenario.
// ---------------------------------------------------------------------------
module tb_i2c_rx_byte_fifo;

   localparam int DEPTH = 8;

   logic       clock = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] inData = 8'h00;
   logic       inValid = 1'b0;
   logic       outReady = 1'b0;
   logic       clrOvf = 1'b0;

   logic [7:0] outData;
   logic       outValid;
   logic [3:0] level;
   logic       full;
   logic       empty;
   logic       overflow;
   logic [7:0] dropCount;

   int checks = 0;
   int errors = 0;

   // Model state: the FIFO contents as a plain queue plus overflow bookkeeping.
   logic [7:0] modelQ[$];
   logic       modelOvf = 1'b0;
   int         modelDrops = 0;

   i2c_rx_byte_fifo #(.DEPTH(8), .ADDR_W(3), .DROP_W(8)) dut (
      .i_clk       (clock),
      .i_rst_n     (rst_n),
      .i_inData    (inData),
      .i_inValid   (inValid),
      .o_outData   (outData),
      .o_outValid  (outValid),
      .i_outReady  (outReady),
      .o_level     (level),
      .o_full      (full),
      .o_empty     (empty),
      .o_overflow  (overflow),
      .o_dropCount (dropCount),
      .i_clrOvf    (clrOvf)
   );

   // 10 time-unit clock.
   always #5 clock = ~clock;

   // One comparison; reports and counts a failure when actual differs.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's worth of inputs.
   task automatic applyStimulus(input logic v, input logic [7:0] d,
                                input logic rdy, input logic clr);
      inValid  = v;
      inData   = d;
      outReady = rdy;
      clrOvf   = clr;
   endtask

   // Let one rising edge pass and settle just after it.
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // Behavioural model: what a FIFO of DEPTH bytes must do on each edge,
   // in terms of a queue rather than pointers.
   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         modelQ.delete();
         modelOvf   = 1'b0;
         modelDrops = 0;
      end else begin
         bit doPop, doPush, doDrop;
         doPop  = (modelQ.size() > 0) && outReady;
         doPush = inValid && ((modelQ.size() < DEPTH) || doPop);
         doDrop = inValid && !doPush;
         if (doPop)  void'(modelQ.pop_front());
         if (doPush) modelQ.push_back(inData);
         if (doDrop) begin
            modelOvf   = 1'b1;
            modelDrops = clrOvf ? 1 : ((modelDrops < 255) ? modelDrops + 1 : 255);
         end else if (clrOvf) begin
            modelOvf   = 1'b0;
            modelDrops = 0;
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clock) begin
      int sz;
      sz = modelQ.size();
      checkOutput("cmp_outValid",  int'(outValid),  (sz > 0) ? 1 : 0);
      checkOutput("cmp_outData",   int'(outData),   (sz > 0) ? int'(modelQ[0]) : 0);
      checkOutput("cmp_level",     int'(level),     sz);
      checkOutput("cmp_full",      int'(full),      (sz == DEPTH) ? 1 : 0);
      checkOutput("cmp_empty",     int'(empty),     (sz == 0) ? 1 : 0);
      checkOutput("cmp_overflow",  int'(overflow),  int'(modelOvf));
      checkOutput("cmp_dropCount", int'(dropCount), modelDrops);
   end

   initial begin
      // Reset.
      #3 rst_n = 1'b0;
      cycle();
      cycle();
      checkOutput("rst_empty",     int'(empty), 1);
      checkOutput("rst_outData",   int'(outData), 8'h00);
      checkOutput("rst_dropCount", int'(dropCount), 0);
      #2 rst_n = 1'b1;
      cycle();

      // T1: single byte falls through, then leaves.
      $display("[TB] T1 single byte");
      applyStimulus(1'b1, 8'hB6, 1'b0, 1'b0);
      cycle();
      checkOutput("t1_outValid", int'(outValid), 1);
      checkOutput("t1_outData",  int'(outData), 8'hB6);
      checkOutput("t1_level",    int'(level), 1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
      checkOutput("t1_empty", int'(empty), 1);

      // T2: fill, then drain in order.
      $display("[TB] T2 fill and drain");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
         cycle();
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t2_full",  int'(full), 1);
      checkOutput("t2_level", int'(level), 8);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput("t2_drainData", int'(outData), i);
         cycle();
      end
      checkOutput("t2_empty", int'(empty), 1);

      // T3: overflow counting, clear, and drop-beats-clear.
      $display("[TB] T3 overflow");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
         cycle();
      end
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
      cycle();
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t3_overflow",  int'(overflow), 1);
      checkOutput("t3_dropCount", int'(dropCount), 2);
      checkOutput("t3_head",      int'(outData), 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      cycle();
      checkOutput("t3_clrOvf",  int'(overflow), 0);
      checkOutput("t3_clrDrop", int'(dropCount), 0);
      applyStimulus(1'b1, 8'hAB, 1'b0, 1'b1);
      cycle();
      checkOutput("t3_setWinsOvf",  int'(overflow), 1);
      checkOutput("t3_setWinsDrop", int'(dropCount), 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      cycle();

      // T4: push and pop together while full.
      $display("[TB] T4 full push with pop");
      applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t4_level",     int'(level), 8);
      checkOutput("t4_dropCount", int'(dropCount), 0);
      checkOutput("t4_head",      int'(outData), 8'h02);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput("t4_drainData", int'(outData), (i < 7) ? i + 2 : 8'h99);
         cycle();
      end

      // T5: push/pop pairs across the pointer wrap, then saturation.
      $display("[TB] T5 wrap and saturation");
      applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
      cycle();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'(8'h41 + i), 1'b1, 1'b0);
         checkOutput("t5_pairHead", int'(outData), 8'h40 + i);
         cycle();
         checkOutput("t5_pairLevel", int'(level), 1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t5_lastHead", int'(outData), 8'h54);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
         cycle();
      end
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t5_satDrop", int'(dropCount), 8'hFF);
      checkOutput("t5_satOvf",  int'(overflow), 1);
      checkOutput("t5_satHead", int'(outData), 8'h54);

      // T6: asynchronous reset with bytes queued.
      $display("[TB] T6 async reset");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t6_level3", int'(level), 3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rstValid", int'(outValid), 0);
      checkOutput("t6_rstLevel", int'(level), 0);
      checkOutput("t6_rstData",  int'(outData), 8'h00);
      checkOutput("t6_rstDrop",  int'(dropCount), 0);
      rst_n = 1'b1;
      cycle();
      applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0);
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t6_head",  int'(outData), 8'h5C);
      checkOutput("t6_level", int'(level), 1);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
